i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

Synthesizable I2C target (slave) with a 256 x 8 register file. It answers one 7-bit device address, accepts pointer-then-data writes and pointer-based reads with auto-increment. It is the responder side of the I2C initiator in the I2C/UART configuration subsystem. It is used as an on-chip stand-in for the HDMI transmitter's configuration port, in simulation and in loopback bring-up on the board.

## Interface
- `DEV_ADDR`, default `7'h39`: 7-bit device address this target acknowledges.
- `RESET_VAL`, default `8'h00`: reset value of every register.
- `clk_i`, input, 1: system clock; all logic is on its rising edge.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `scl_i`, input, 1: I2C clock as seen on the bus, asynchronous to `clk_i`.
- `sda_i`, input, 1: I2C data as seen on the bus, asynchronous to `clk_i`.
- `sda_oe_o`, output, 1: open-drain enable. 1 pulls SDA low; 0 releases it.
- `wr_stb_o`, output, 1: one-cycle pulse for each register written over I2C.
- `wr_addr_o`, output, 8: register index of the current `wr_stb_o` pulse.
- `wr_data_o`, output, 8: data of the current `wr_stb_o` pulse.
- `busy_o`, output, 1: high from an addressed START through the next STOP.
- `dbg_addr_i`, input, 8: debug read index.
- `dbg_data_o`, output, 8: register value at `dbg_addr_i`, combinational.

## Operation
- `scl_i` and `sda_i` each pass through a 2-flop synchronizer and one history flop. Edges are detected on the synchronized values.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Both are valid in any state and take priority over bit sampling in the same cycle.
- Data bits are sampled on the SCL rising edge, MSB first. The target changes `sda_oe_o` only on an SCL falling edge.
- The bit counter is 3 bits. It counts SCL rising edges within a byte; the 9th edge is the ACK slot.
- States:
  - IDLE: waiting for a START.
  - ADDR: shift in 7 address bits plus the R/W bit.
  - ADDR_ACK: drive ACK if the address matches; otherwise go to IGNORE with SDA released.
  - PTR: receive the register pointer byte.
  - PTR_ACK: drive ACK for the pointer byte.
  - WDATA: receive a write data byte.
  - WDATA_ACK: drive ACK for the data byte.
  - RDATA: drive `reg[ptr]` onto SDA.
  - RDATA_ACK: release SDA and sample the initiator's ACK/NACK.
  - IGNORE: stay here until the next START or STOP.
- Write transaction, W bit = 0:
  - The first byte after the address loads `ptr`.
  - Each following byte writes `reg[ptr]` and pulses `wr_stb_o` once, during the cycle after the ACK-slot falling edge. `ptr` then increments.
  - `ptr` wraps from 8'hFF to 8'h00.
- Read transaction, R bit = 1:
  - The target sends `reg[ptr]` starting at the current `ptr`.
  - On an initiator ACK, `ptr` increments (with wrap) and the next byte is sent.
  - On an initiator NACK, the target goes to IGNORE.
- A repeated START from any state returns to ADDR. `ptr` is kept, so a write of the pointer followed by a repeated START and a read works.
- STOP from any state returns to IDLE, sets `sda_oe_o` to 0 and clears `busy_o`.
- In every state except the ACK states and RDATA, `sda_oe_o` is 0.

## Timing
- Reset values:
  - `sda_oe_o` = 0, `wr_stb_o` = 0, `busy_o` = 0.
  - `wr_addr_o` = 0, `wr_data_o` = 0.
  - `ptr` = 0, all registers = `RESET_VAL`, state = IDLE.
- Bus edge to internal detection: 3 `clk_i` cycles.
- `sda_oe_o` updates 1 cycle after a detected SCL falling edge. Worst case, that is 4 `clk_i` cycles after the bus edge.
- Minimum SCL high time and low time: 6 `clk_i` cycles each. The initiator's divider of 126 satisfies this with large margin.
- `busy_o` rises 1 cycle after the address ACK decision and falls 1 cycle after STOP is detected.
- When a write and a debug read hit the same index in the same cycle, `dbg_data_o` shows the new value from the next cycle.
- Reset asserted mid-transaction:
  - Everything returns to reset values immediately, and SDA is released asynchronously.
  - After reset is released, bus activity is ignored until the next START.

## Test plan
- Write 0x72 (address 0x39 + W), 0x41, 0x10, 0x20, then STOP:
  - ACK on all 4 bytes.
  - `wr_stb_o` pulses twice: (0x41, 0x10), then (0x42, 0x20).
  - `dbg_data_o` at 0x42 reads 0x20.
- Write pointer 0x41, repeated START, 0x73, read 2 bytes (ACK then NACK), STOP:
  - SDA returns 0x10 then 0x20.
  - `busy_o` falls after STOP.
- Address 0x74 (device 0x3A): no ACK, SDA released for the whole transaction, no `wr_stb_o`, `busy_o` stays 0.
- Pointer 0xFF, write 0xAA, 0xBB: `reg[0xFF]` = 0xAA and `reg[0x00]` = 0xBB (pointer wrap).
- Assert `rst_n_i` during the 4th data bit of a write:
  - `sda_oe_o` = 0 in the same cycle, and all registers read `RESET_VAL`.
  - The next full transaction completes normally.
- STOP in the middle of a byte: no write occurs, the state returns to IDLE, and the next START is accepted.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target answering one device address, fronting a 256 x 8 register file
`timescale 1ns/1ps

module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       wr_stb_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o,
    input  logic [7:0] dbg_addr_i,
    output logic [7:0] dbg_data_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [2:0] scl_sh, sda_sh;
    logic [2:0] bit_cnt;
    logic       byte_rdy;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic       rw;
    logic       nack;
    logic [7:0] mem [256];

    // [0] and [1] form the synchronizer, [2] is the history flop for edge detection
    logic scl_s, scl_d, sda_s, sda_d;
    assign scl_s = scl_sh[1];
    assign scl_d = scl_sh[2];
    assign sda_s = sda_sh[1];
    assign sda_d = sda_sh[2];

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    logic [7:0] rx_byte, ptr_nxt;
    assign rx_byte = {shreg[6:0], sda_s};
    assign ptr_nxt = ptr + 8'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sh <= 3'b111;
            sda_sh <= 3'b111;
        end else begin
            scl_sh <= {scl_sh[1:0], scl_i};
            sda_sh <= {sda_sh[1:0], sda_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_rdy  <= 1'b0;
            shreg     <= 8'h00;
            ptr       <= 8'h00;
            rw        <= 1'b0;
            nack      <= 1'b0;
            sda_oe_o  <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= 8'h00;
            wr_data_o <= 8'h00;
            busy_o    <= 1'b0;
        end else begin
            wr_stb_o <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= 3'd0;
                byte_rdy <= 1'b0;
                sda_oe_o <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                bit_cnt  <= 3'd0;
                byte_rdy <= 1'b0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                if (scl_rise && (state == ADDR || state == PTR || state == WDATA || state == RDATA)) begin
                    if (state != RDATA) shreg <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_rdy <= 1'b1;
                end
                case (state)
                    ADDR: if (scl_fall && byte_rdy) begin
                        byte_rdy <= 1'b0;
                        if (shreg[7:1] == DEV_ADDR) begin
                            state    <= ADDR_ACK;
                            sda_oe_o <= 1'b1;
                            busy_o   <= 1'b1;
                            rw       <= shreg[0];
                        end else begin
                            state <= IGNORE;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        bit_cnt <= 3'd0;
                        if (rw) begin
                            state    <= RDATA;
                            shreg    <= mem[ptr];
                            sda_oe_o <= ~mem[ptr][7];
                        end else begin
                            state    <= PTR;
                            sda_oe_o <= 1'b0;
                        end
                    end
                    PTR: if (scl_fall && byte_rdy) begin
                        byte_rdy <= 1'b0;
                        ptr      <= shreg;
                        state    <= PTR_ACK;
                        sda_oe_o <= 1'b1;
                    end
                    PTR_ACK: if (scl_fall) begin
                        state    <= WDATA;
                        bit_cnt  <= 3'd0;
                        sda_oe_o <= 1'b0;
                    end
                    WDATA: if (scl_fall && byte_rdy) begin
                        byte_rdy <= 1'b0;
                        state    <= WDATA_ACK;
                        sda_oe_o <= 1'b1;
                    end
                    // The write commits only once the ACK slot has closed
                    WDATA_ACK: if (scl_fall) begin
                        state     <= WDATA;
                        bit_cnt   <= 3'd0;
                        sda_oe_o  <= 1'b0;
                        wr_stb_o  <= 1'b1;
                        wr_addr_o <= ptr;
                        wr_data_o <= shreg;
                        ptr       <= ptr_nxt;
                    end
                    RDATA: if (scl_fall) begin
                        if (byte_rdy) begin
                            byte_rdy <= 1'b0;
                            state    <= RDATA_ACK;
                            sda_oe_o <= 1'b0;
                        end else begin
                            sda_oe_o <= ~shreg[6];
                            shreg    <= {shreg[6:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) nack <= sda_s;
                        if (scl_fall) begin
                            if (nack) begin
                                state    <= IGNORE;
                                sda_oe_o <= 1'b0;
                            end else begin
                                ptr      <= ptr_nxt;
                                shreg    <= mem[ptr_nxt];
                                sda_oe_o <= ~mem[ptr_nxt][7];
                                state    <= RDATA;
                                bit_cnt  <= 3'd0;
                            end
                        end
                    end
                    default: sda_oe_o <= 1'b0;
                endcase
            end
        end
    end

    // Array updates from the registered strobe, so a same-index debug read sees it next cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 256; i++) mem[i] <= RESET_VAL;
        end else if (wr_stb_o) begin
            mem[wr_addr_o] <= wr_data_o;
        end
    end

    assign dbg_data_o = mem[dbg_addr_i];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
`timescale 1ns/1ps

module tb_i2c_target_regfile;

    localparam logic [6:0] DEV = 7'h39;
    localparam logic [7:0] RV  = 8'hC3;
    localparam int Q = 60;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_stb, busy;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target_regfile #(.DEV_ADDR(DEV), .RESET_VAL(RV)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl_drv), .sda_i(sda_bus),
        .sda_oe_o(sda_oe), .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .busy_o(busy), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ptr, d0, d1, a0, a1;
    } vec_t;
    typedef struct {
        logic [7:0] addr, data;
    } wr_t;

    vec_t       vecs [4];
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    logic [7:0] model [256];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         oe_seen, busy_seen;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (rst_n && wr_stb) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_wr_stb", {wr_addr, wr_data}, 16'hxxxx);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
        model[a] = d;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; scl_drv = 1'b1; #Q;
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #Q;
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; #Q;
        scl_drv = 1'b1; #Q;
        sda_drv = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; #Q;
        scl_drv = 1'b1; #H;
        scl_drv = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #(H/2);
        b = sda_bus; #(H/2);
        scl_drv = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic dbg_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a; #10;
        check(name, dbg_data, exp);
    endtask

    task automatic xfer_write(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1);
        logic ack;
        i2c_start();
        write_byte({DEV, 1'b0}, ack); check("w_addr_ack", ack, 1'b1);
        check("w_busy", busy, 1'b1);
        write_byte(p, ack); check("w_ptr_ack", ack, 1'b1);
        expect_write(p, d0);
        write_byte(d0, ack); check("w_d0_ack", ack, 1'b1);
        expect_write(p + 8'd1, d1);
        write_byte(d1, ack); check("w_d1_ack", ack, 1'b1);
        i2c_stop(); #H;
        check("w_busy_after_stop", busy, 1'b0);
        check("w_pending_writes", exp_wr.size(), 0);
    endtask

    task automatic xfer_read(input logic [7:0] p);
        logic ack;
        logic [7:0] d;
        i2c_start();
        write_byte({DEV, 1'b0}, ack); check("r_addr_ack", ack, 1'b1);
        write_byte(p, ack); check("r_ptr_ack", ack, 1'b1);
        i2c_rstart();
        write_byte({DEV, 1'b1}, ack); check("r_addr_rd_ack", ack, 1'b1);
        exp_rd.push_back(model[p]);
        exp_rd.push_back(model[p + 8'd1]);
        read_byte(1'b1, d); check("r_byte0", d, exp_rd.pop_front());
        read_byte(1'b0, d); check("r_byte1", d, exp_rd.pop_front());
        check("r_busy", busy, 1'b1);
        i2c_stop(); #H;
        check("r_busy_after_stop", busy, 1'b0);
        check("r_sda_released", sda_oe, 1'b0);
    endtask

    initial begin
        logic ack;
        dbg_addr = 8'h00;
        for (int i = 0; i < 256; i++) model[i] = RV;
        vecs[0] = '{8'h41, 8'h10, 8'h20, 8'h41, 8'h42};
        vecs[1] = '{8'hFF, 8'hAA, 8'hBB, 8'hFF, 8'h00};
        vecs[2] = '{8'h80, 8'h5A, 8'hA5, 8'h80, 8'h81};
        vecs[3] = '{8'h7F, 8'h01, 8'hFE, 8'h7F, 8'h80};

        #20;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        check("rst_wr_data", wr_data, 8'h00);
        dbg_check("rst_reg00", 8'h00, RV);
        dbg_check("rst_regff", 8'hFF, RV);
        rst_n = 1'b1; #100;

        for (int v = 0; v < 4; v++) begin
            xfer_write(vecs[v].ptr, vecs[v].d0, vecs[v].d1);
            dbg_check("vec_dbg_a0", vecs[v].a0, vecs[v].d0);
            dbg_check("vec_dbg_a1", vecs[v].a1, vecs[v].d1);
            xfer_read(vecs[v].ptr);
            #H;
        end

        // Foreign device address: no ACK, bus untouched, no busy
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte({7'h3A, 1'b0}, ack); check("foreign_addr_nack", ack, 1'b0);
        write_byte(8'h55, ack); check("foreign_data_nack", ack, 1'b0);
        i2c_stop(); #H;
        check("foreign_oe_seen", oe_seen, 1'b0);
        check("foreign_busy_seen", busy_seen, 1'b0);

        // STOP halfway through a data byte
        i2c_start();
        write_byte({DEV, 1'b0}, ack); check("midstop_addr_ack", ack, 1'b1);
        write_byte(8'h10, ack); check("midstop_ptr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop(); #H;
        check("midstop_busy", busy, 1'b0);
        dbg_check("midstop_reg10", 8'h10, model[8'h10]);
        xfer_write(8'h10, 8'h3C, 8'h96);
        dbg_check("midstop_after_reg11", 8'h11, 8'h96);

        // Reset during the 4th data bit of a write
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h30, ack);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #(H/2);
        rst_n = 1'b0; #1;
        check("rst_mid_sda_oe", sda_oe, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        for (int i = 0; i < 256; i++) model[i] = RV;
        #9;
        dbg_check("rst_mid_reg41", 8'h41, RV);
        dbg_check("rst_mid_regff", 8'hFF, RV);
        rst_n = 1'b1; #(H/2 - 20);
        scl_drv = 1'b0; #Q;
        oe_seen = 1'b0; busy_seen = 1'b0;
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        write_bit(1'b1);
        check("rst_ignore_oe", oe_seen, 1'b0);
        check("rst_ignore_busy", busy_seen, 1'b0);
        i2c_stop(); #H;
        xfer_write(8'h30, 8'h66, 8'h77);
        xfer_read(8'h30);

        // Reset while the target is driving an ACK releases SDA without a clock edge
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : DEV[i-1]);
        sda_drv = 1'b1; #Q;
        scl_drv = 1'b1; #(H/2);
        check("ack_before_rst", sda_oe, 1'b1);
        rst_n = 1'b0; #1;
        check("ack_async_release", sda_oe, 1'b0);
        for (int i = 0; i < 256; i++) model[i] = RV;
        #9;
        scl_drv = 1'b0; #Q;
        rst_n = 1'b1; #Q;
        i2c_stop(); #H;
        xfer_write(8'h00, 8'hE1, 8'h1E);
        xfer_read(8'h00);

        check("final_pending_writes", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
